c512to8: RTL and testbench

- Egress width converter: takes 480-bit words plus 32-bit control from a crossbar output port and emits one byte per clock with packet delimiters.
- Undoes the ingress byte-to-word packing, so the switch output can be checked byte-for-byte against the pcap stream fed in.
- Sits directly downstream of one crossbar output (out_wrN/out_ctlN/out_dataN).
- Contains a small word FIFO, because the crossbar has no backpressure and a word arrives in one cycle but takes up to 60 cycles to drain.

---
 rtl/c512to8.sv | 170 +++++++++++++++++
 tb/tb_c512to8.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/c512to8.sv
// c512to8 -- egress width converter.
//
// Takes 480-bit words (plus 32-bit control) from one crossbar output port and
// replays them as a byte stream with packet delimiters. This undoes the
// ingress byte-to-word packing. The crossbar cannot be back-pressured, so
// words land in a small show-ahead FIFO. A word stays at the FIFO head until
// its last valid byte has been emitted.
//
// Ports:
//   clk           rising-edge clock
//   rst           synchronous reset, active-low (0 = reset, 1 = run)
//   datavalid     write strobe for in_ctl/in_data
//   in_ctl        [31]=SOP, [30]=EOP, [5:0]=valid byte count (0 or >BYTES -> BYTES)
//   in_data       byte 0 in the top 8 bits, following bytes descending
//   pause         downstream stall; no byte is emitted on a paused edge
//   in_rdy        registered "FIFO not full", advisory to upstream
//   overflow      sticky flag: a write arrived while the FIFO was full
//   data_out      output byte (holds its value when not valid)
//   dataout_valid data_out valid this cycle
//   newpkt        first byte of an SOP word
//   lastbyte      final valid byte of an EOP word
//   busy          FSM not idle or FIFO non-empty
module c512to8 #(
  parameter int DATA_WIDTH = 480,
  parameter int CTRL_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int IPG_CYCLES = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  datavalid,
  input  logic [CTRL_WIDTH-1:0] in_ctl,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  pause,
  output logic                  in_rdy,
  output logic                  overflow,
  output logic [7:0]            data_out,
  output logic                  dataout_valid,
  output logic                  newpkt,
  output logic                  lastbyte,
  output logic                  busy
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int IDX_W = $clog2(BYTES + 1);
  // Only the fields used downstream are stored: SOP, EOP, len[5:0], data.
  localparam int ENT_W = DATA_WIDTH + 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [ENT_W-1:0]      mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        count, count_nxt;
  logic [IDX_W-1:0]      idx, idx_nxt;
  logic [7:0]            gap_cnt, gap_nxt;

  logic [ENT_W-1:0]      head;
  logic                  head_sop, head_eop;
  logic [IDX_W-1:0]      head_len;
  logic [DATA_WIDTH-1:0] head_data;
  logic [7:0]            cur_byte;
  logic                  emit, last, pop, wr_acc;

  // Zero or out-of-range lengths mean a full word.
  function automatic logic [IDX_W-1:0] eff_len(input logic [5:0] l);
    if (l == 6'd0 || int'(l) > BYTES) return IDX_W'(BYTES);
    return IDX_W'(l);
  endfunction

  // Byte i sits at [DATA_WIDTH-1-8*i -: 8]; shift it up to the top.
  function automatic logic [7:0] pick_byte(input logic [DATA_WIDTH-1:0] d,
                                           input logic [IDX_W-1:0] i);
    logic [DATA_WIDTH-1:0] s;
    s = d << {i, 3'b000};
    return s[DATA_WIDTH-1 -: 8];
  endfunction

  // ---- head of FIFO (show-ahead) / emit decision ----
  assign head      = mem[rd_ptr];
  assign head_sop  = head[ENT_W-1];
  assign head_eop  = head[ENT_W-2];
  assign head_len  = eff_len(head[ENT_W-3 -: 6]);
  assign head_data = head[DATA_WIDTH-1:0];
  assign cur_byte  = pick_byte(head_data, idx);

  // SEND always has its word at the head, so one condition covers IDLE and SEND.
  assign emit   = !pause && (state != GAP) && (count != '0);
  assign last   = (idx == head_len - 1'b1);
  assign pop    = emit && last;
  // A pop on the same edge frees a slot, so a write into a full FIFO is taken.
  assign wr_acc = datavalid && ((count != (PTR_W+1)'(FIFO_DEPTH)) || pop);
  assign count_nxt = count + (PTR_W+1)'(wr_acc) - (PTR_W+1)'(pop);

  assign busy = (state != IDLE) || (count != '0);

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    gap_nxt   = gap_cnt;
    case (state)
      IDLE, SEND: begin
        if (emit) begin
          if (last) begin
            idx_nxt = '0;
            if (head_eop && IPG_CYCLES > 0) begin
              state_nxt = GAP;
              gap_nxt   = 8'(IPG_CYCLES - 1);
            end else begin
              state_nxt = (count_nxt != '0) ? SEND : IDLE;
            end
          end else begin
            idx_nxt   = idx + 1'b1;
            state_nxt = SEND;
          end
        end
      end
      GAP: begin
        // The gap runs on every edge, paused or not.
        if (gap_cnt == 8'd0) state_nxt = IDLE;
        else                 gap_nxt   = gap_cnt - 8'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---- FIFO storage (data only, not reset) ----
  always_ff @(posedge clk) begin
    if (rst && wr_acc)
      mem[wr_ptr] <= {in_ctl[31], in_ctl[30], in_ctl[5:0], in_data};
  end

  // ---- control and output registers ----
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      idx           <= '0;
      gap_cnt       <= 8'd0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      in_rdy        <= 1'b1;
      overflow      <= 1'b0;
      data_out      <= 8'd0;
      dataout_valid <= 1'b0;
      newpkt        <= 1'b0;
      lastbyte      <= 1'b0;
    end else begin
      state   <= state_nxt;
      idx     <= idx_nxt;
      gap_cnt <= gap_nxt;
      count   <= count_nxt;
      in_rdy  <= (count_nxt != (PTR_W+1)'(FIFO_DEPTH));
      if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      if (datavalid && !wr_acc) overflow <= 1'b1;
      dataout_valid <= emit;
      newpkt        <= emit && (idx == '0) && head_sop;
      lastbyte      <= emit && last && head_eop;
      if (emit) data_out <= cur_byte;
    end
  end

endmodule

// File: tb/tb_c512to8.sv
// Directed testbench for c512to8: a zero-gap instance and a 12-cycle-gap
// instance share the same stimulus; each output stream is logged with cycle
// stamps and compared against hand-derived expectations.
module tb_c512to8;

  logic         clk = 1'b0;
  logic         rst, datavalid, pause;
  logic [31:0]  in_ctl;
  logic [479:0] in_data;

  logic       in_rdy, overflow, dv, np, lb, busy;
  logic [7:0] d_out;
  logic       g_in_rdy, g_overflow, g_dv, g_np, g_lb, g_busy;
  logic [7:0] g_out;

  c512to8 #(.DATA_WIDTH(480), .CTRL_WIDTH(32), .FIFO_DEPTH(4), .IPG_CYCLES(0)) u_dut (
    .clk(clk), .rst(rst), .datavalid(datavalid), .in_ctl(in_ctl), .in_data(in_data),
    .pause(pause), .in_rdy(in_rdy), .overflow(overflow), .data_out(d_out),
    .dataout_valid(dv), .newpkt(np), .lastbyte(lb), .busy(busy));

  c512to8 #(.DATA_WIDTH(480), .CTRL_WIDTH(32), .FIFO_DEPTH(4), .IPG_CYCLES(12)) u_gap (
    .clk(clk), .rst(rst), .datavalid(datavalid), .in_ctl(in_ctl), .in_data(in_data),
    .pause(pause), .in_rdy(g_in_rdy), .overflow(g_overflow), .data_out(g_out),
    .dataout_valid(g_dv), .newpkt(g_np), .lastbyte(g_lb), .busy(g_busy));

  always #5 clk = ~clk;

  int nchecks = 0;
  int nfail   = 0;
  int cyc     = 0;
  int pviol   = 0;
  int g_nsum  = 0;
  int g_lsum  = 0;

  logic [7:0] b_q[$];
  bit         n_q[$];
  bit         l_q[$];
  int         t_q[$];
  int         w_q[$];
  logic [7:0] gb_q[$];
  int         gt_q[$];

  // Log writes at the edge, outputs 1 time unit after it.
  always @(posedge clk) begin
    logic p_s;
    cyc = cyc + 1;
    p_s = pause;
    if (datavalid && rst) w_q.push_back(cyc);
    #1;
    if (dv) begin
      b_q.push_back(d_out);
      n_q.push_back(np);
      l_q.push_back(lb);
      t_q.push_back(cyc);
      if (p_s) pviol++;
    end
    if (g_dv) begin
      gb_q.push_back(g_out);
      gt_q.push_back(cyc);
      if (g_np) g_nsum++;
      if (g_lb) g_lsum++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchecks++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr();
    b_q.delete(); n_q.delete(); l_q.delete(); t_q.delete(); w_q.delete();
    gb_q.delete(); gt_q.delete();
    pviol = 0; g_nsum = 0; g_lsum = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0; datavalid = 1'b0; pause = 1'b0; in_ctl = '0; in_data = '0;
    tick(2);
    rst = 1'b1;
    clr();
  endtask

  task automatic wr(input logic [31:0] c, input logic [479:0] d);
    in_ctl = c; in_data = d; datavalid = 1'b1;
    tick(1);
    datavalid = 1'b0;
  endtask

  function automatic logic [479:0] mkword(input int base);
    logic [479:0] w;
    w = '0;
    for (int i = 0; i < 60; i++) w[479-8*i -: 8] = 8'(base + i);
    return w;
  endfunction

  // Mismatches against an ascending byte run; -1 if the length is wrong.
  function automatic int byte_errs(input int n, input int base);
    int e;
    e = 0;
    if (b_q.size() != n) return -1;
    for (int i = 0; i < n; i++) if (b_q[i] !== 8'(base + i)) e++;
    return e;
  endfunction

  function automatic int nsum();
    int s;
    s = 0;
    foreach (n_q[i]) s += int'(n_q[i]);
    return s;
  endfunction

  function automatic int lsum();
    int s;
    s = 0;
    foreach (l_q[i]) s += int'(l_q[i]);
    return s;
  endfunction

  function automatic int span(input int a, input int b);
    if (t_q.size() <= b) return -1;
    return t_q[b] - t_q[a];
  endfunction

  initial begin
    int e, nb, budget;

    // Reset values
    do_reset();
    check("rst_data_out", d_out, 8'h00);
    check("rst_valid", dv, 1'b0);
    check("rst_newpkt", np, 1'b0);
    check("rst_lastbyte", lb, 1'b0);
    check("rst_overflow", overflow, 1'b0);
    check("rst_in_rdy", in_rdy, 1'b1);
    check("rst_busy", busy, 1'b0);

    // Single full word, SOP+EOP
    wr(32'hC000_003C, mkword(0));
    check("t1_busy", busy, 1'b1);
    tick(70);
    check("t1_bytes", byte_errs(60, 0), 0);
    check("t1_latency", (t_q.size() > 0 && w_q.size() > 0) ? t_q[0] - w_q[0] : -1, 1);
    check("t1_contig", span(0, 59), 59);
    check("t1_newpkt_pos", (n_q.size() > 0) ? n_q[0] : 1'b0, 1'b1);
    check("t1_newpkt_cnt", nsum(), 1);
    check("t1_last_pos", (l_q.size() > 59) ? l_q[59] : 1'b0, 1'b1);
    check("t1_last_cnt", lsum(), 1);
    check("t1_idle_busy", busy, 1'b0);

    // 64-byte packet over two words
    do_reset();
    wr(32'h8000_003C, mkword(0));
    wr(32'h4000_0004, mkword(60));
    tick(80);
    check("t2_bytes", byte_errs(64, 0), 0);
    check("t2_contig", span(0, 63), 63);
    check("t2_word_seam", span(59, 60), 1);
    check("t2_newpkt_cnt", nsum(), 1);
    check("t2_last_pos", (l_q.size() > 63) ? l_q[63] : 1'b0, 1'b1);
    check("t2_last_cnt", lsum(), 1);

    // Same packet, pause toggling every 3 cycles
    do_reset();
    for (int c = 0; c < 160; c++) begin
      pause = ((c / 3) % 2) == 1;
      if (c == 0) begin
        in_ctl = 32'h8000_003C; in_data = mkword(0); datavalid = 1'b1;
      end else if (c == 1) begin
        in_ctl = 32'h4000_0004; in_data = mkword(60); datavalid = 1'b1;
      end else begin
        datavalid = 1'b0;
      end
      tick(1);
    end
    pause = 1'b0;
    tick(5);
    check("t3_bytes", byte_errs(64, 0), 0);
    check("t3_paused_valid", pviol, 0);
    check("t3_newpkt_cnt", nsum(), 1);
    check("t3_last_cnt", lsum(), 1);

    // Overflow: six words into a 4-deep FIFO
    do_reset();
    for (int j = 0; j < 6; j++) begin
      in_ctl = 32'hC000_003C; in_data = mkword(j * 64); datavalid = 1'b1;
      tick(1);
      if (j == 2) check("t4_rdy_3", in_rdy, 1'b1);
      if (j == 3) begin
        check("t4_rdy_full", in_rdy, 1'b0);
        check("t4_ovf_before", overflow, 1'b0);
      end
      if (j == 4) check("t4_ovf_set", overflow, 1'b1);
    end
    datavalid = 1'b0;
    tick(260);
    e = 0;
    if (b_q.size() != 240) e = -1;
    else
      for (int p = 0; p < 4; p++)
        for (int i = 0; i < 60; i++)
          if (b_q[p*60+i] !== 8'(p*64 + i)) e++;
    check("t4_bytes", e, 0);
    check("t4_newpkt_cnt", nsum(), 4);
    check("t4_last_cnt", lsum(), 4);
    check("t4_ovf_sticky", overflow, 1'b1);
    check("t4_rdy_after", in_rdy, 1'b1);

    // Inter-packet gap with two 1-byte packets
    do_reset();
    in_data = '0;
    wr(32'hC000_0001, {8'hA1, 472'd0});
    wr(32'hC000_0001, {8'hB2, 472'd0});
    tick(40);
    check("t5_gap_cnt", gb_q.size(), 2);
    check("t5_gap_spacing", (gt_q.size() > 1) ? gt_q[1] - gt_q[0] : -1, 13);
    check("t5_gap_b0", (gb_q.size() > 0) ? gb_q[0] : 8'h00, 8'hA1);
    check("t5_gap_b1", (gb_q.size() > 1) ? gb_q[1] : 8'h00, 8'hB2);
    check("t5_gap_newpkt", g_nsum, 2);
    check("t5_gap_last", g_lsum, 2);
    check("t5_nogap_spacing", span(0, 1), 1);

    // len=0 means a full word
    do_reset();
    wr(32'hC000_0000, mkword(5));
    tick(70);
    check("t5_len0_bytes", byte_errs(60, 5), 0);
    check("t5_len0_last", (l_q.size() > 59) ? l_q[59] : 1'b0, 1'b1);

    // Reset in the middle of a word
    do_reset();
    wr(32'hC000_003C, mkword(0));
    budget = 100;
    while (b_q.size() < 30 && budget > 0) begin
      tick(1);
      budget--;
    end
    check("t6_reached_30", b_q.size(), 30);
    rst = 1'b0;
    tick(1);
    check("t6_rst_valid", dv, 1'b0);
    check("t6_rst_data", d_out, 8'h00);
    check("t6_rst_newpkt", np, 1'b0);
    check("t6_rst_last", lb, 1'b0);
    check("t6_rst_rdy", in_rdy, 1'b1);
    check("t6_rst_busy", busy, 1'b0);
    rst = 1'b1;
    nb = b_q.size();
    tick(100);
    check("t6_quiet", b_q.size(), nb);
    check("t6_quiet_busy", busy, 1'b0);
    wr(32'hC000_003C, mkword(8'h80));
    tick(70);
    check("t6_resume_cnt", b_q.size(), nb + 60);
    check("t6_resume_b0", (b_q.size() > nb) ? b_q[nb] : 8'h00, 8'h80);

    $display("TB_RESULT checks=%0d failures=%0d", nchecks, nfail);
    $finish;
  end

endmodule
